core_seq_ctrl: RTL and testbench

Multi-cycle sequencing FSM for the tiny-riscv core. It drives instruction fetch, the single-cycle decode/execute step, data-memory access, register-file writeback and PC update. It consumes the instruction-class flags from the decode unit and the ALU compare result. All memory interfaces use valid/ready requests followed by a response-valid pulse.

---
 rtl/core_seq_ctrl_if.sv | 40 ++++
 rtl/core_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_seq_ctrl_if.sv
// Decode flags, memory handshakes and control strobes between core_seq_ctrl (master) and the core (slave).
interface core_seq_ctrl_if;
  logic       is_load_op;
  logic       is_store_op;
  logic       is_br_type;
  logic       is_jump_op;
  logic       br_taken;
  logic [1:0] mem_addr_lo;
  logic [1:0] tgt_addr_lo;
  logic [1:0] mem_size;
  logic       imem_req_valid;
  logic       imem_req_ready;
  logic       imem_rsp_valid;
  logic       instr_en;
  logic       dmem_req_valid;
  logic       dmem_we;
  logic       dmem_req_ready;
  logic       dmem_rsp_valid;
  logic       rf_we;
  logic       pc_en;
  logic       pc_sel;
  logic       trap;
  logic [2:0] state;

  modport master (
    input  is_load_op, is_store_op, is_br_type, is_jump_op, br_taken,
    input  mem_addr_lo, tgt_addr_lo, mem_size,
    input  imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid,
    output imem_req_valid, instr_en, dmem_req_valid, dmem_we,
    output rf_we, pc_en, pc_sel, trap, state
  );

  modport slave (
    output is_load_op, is_store_op, is_br_type, is_jump_op, br_taken,
    output mem_addr_lo, tgt_addr_lo, mem_size,
    output imem_req_ready, imem_rsp_valid, dmem_req_ready, dmem_rsp_valid,
    input  imem_req_valid, instr_en, dmem_req_valid, dmem_we,
    input  rf_we, pc_en, pc_sel, trap, state
  );
endinterface

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the tiny-riscv core: fetch, execute, data access, writeback, PC update.
// Define MISALIGN_TRAP_EN to trap misaligned data accesses and jump/branch targets into a sticky TRAP state.
module core_seq_ctrl #(
  parameter int RESET_DELAY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  core_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT_I = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WAIT_D = 3'd5,
    S_WB     = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam int CNT_W = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_DELAY - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_rst_cnt;
  logic             r_is_store;

  logic w_is_mem;
  logic w_misalign;
  logic w_imem_req_valid;
  logic w_instr_en;
  logic w_dmem_req_valid;
  logic w_dmem_we;
  logic w_rf_we;
  logic w_pc_en;
  logic w_pc_sel;
  logic w_trap;

  assign w_is_mem = bus.is_load_op | bus.is_store_op;

`ifdef MISALIGN_TRAP_EN
  logic w_mem_misalign;
  logic w_tgt_misalign;

  assign w_mem_misalign = ((bus.mem_size == 2'd1) && bus.mem_addr_lo[0]) ||
                          ((bus.mem_size == 2'd2) && (bus.mem_addr_lo != 2'd0));
  // Only control transfers that actually redirect the PC can fault on their target.
  assign w_tgt_misalign = (bus.is_jump_op || (bus.is_br_type && bus.br_taken)) &&
                          bus.tgt_addr_lo[1];
  assign w_misalign     = w_is_mem ? w_mem_misalign : w_tgt_misalign;
`else
  logic w_unused_align;

  assign w_unused_align = ^{bus.mem_addr_lo, bus.tgt_addr_lo, bus.mem_size};
  assign w_misalign     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_cnt <= '0;
    end else if ((r_state == S_RESET) && (r_rst_cnt != RST_LAST)) begin
      r_rst_cnt <= r_rst_cnt + 1'b1;
    end
  end

  // Captured in EXEC so dmem_we cannot move while the data request waits for ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_store <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_is_store <= bus.is_store_op;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_imem_req_valid = 1'b0;
    w_instr_en       = 1'b0;
    w_dmem_req_valid = 1'b0;
    w_dmem_we        = 1'b0;
    w_rf_we          = 1'b0;
    w_pc_en          = 1'b0;
    w_pc_sel         = 1'b0;
    w_trap           = 1'b0;
    case (r_state)
      S_RESET: begin
        if (r_rst_cnt == RST_LAST) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        w_imem_req_valid = 1'b1;
        if (bus.imem_req_ready) begin
          w_state_nxt = S_WAIT_I;
        end
      end
      S_WAIT_I: begin
        if (bus.imem_rsp_valid) begin
          w_instr_en  = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_misalign) begin
          w_state_nxt = S_TRAP;
        end else if (w_is_mem) begin
          w_state_nxt = S_MEM;
        end else begin
          w_pc_en     = 1'b1;
          w_state_nxt = S_FETCH;
          if (bus.is_jump_op) begin
            w_rf_we  = 1'b1;
            w_pc_sel = 1'b1;
          end else if (bus.is_br_type) begin
            w_pc_sel = bus.br_taken;
          end else begin
            w_rf_we = 1'b1;
          end
        end
      end
      S_MEM: begin
        w_dmem_req_valid = 1'b1;
        w_dmem_we        = r_is_store;
        if (bus.dmem_req_ready) begin
          if (r_is_store) begin
            w_pc_en     = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WAIT_D;
          end
        end
      end
      S_WAIT_D: begin
        if (bus.dmem_rsp_valid) begin
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        w_rf_we     = 1'b1;
        w_pc_en     = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_TRAP: begin
`ifdef MISALIGN_TRAP_EN
        w_trap = 1'b1;
`endif
      end
      default: begin
        w_state_nxt = S_RESET;
      end
    endcase
  end

  assign bus.imem_req_valid = w_imem_req_valid;
  assign bus.instr_en       = w_instr_en;
  assign bus.dmem_req_valid = w_dmem_req_valid;
  assign bus.dmem_we        = w_dmem_we;
  assign bus.rf_we          = w_rf_we;
  assign bus.pc_en          = w_pc_en;
  assign bus.pc_sel         = w_pc_sel;
  assign bus.trap           = w_trap;
  assign bus.state          = r_state;

  a_imem_hold: assert property (@(posedge clk) disable iff (!rst_n)
    bus.imem_req_valid && !bus.imem_req_ready |=> bus.imem_req_valid);
  a_dmem_hold: assert property (@(posedge clk) disable iff (!rst_n)
    bus.dmem_req_valid && !bus.dmem_req_ready |=> bus.dmem_req_valid && $stable(bus.dmem_we));
  a_instr_excl: assert property (@(posedge clk) disable iff (!rst_n)
    bus.instr_en |-> !(bus.rf_we || bus.pc_en));

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Scoreboard bench for core_seq_ctrl: expected retire strobes and latency queued per instruction, checked on pc_en.
module tb_core_seq_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  core_seq_ctrl_if bus_if();

  core_seq_ctrl #(.RESET_DELAY(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic rf_we;
    logic pc_sel;
    int   lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   mon_lat = 0;
  logic mon_prev_iv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Retire monitor: latency runs from the first FETCH cycle to the pc_en cycle inclusive.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mon_lat     = 0;
      mon_prev_iv = 1'b0;
    end else begin
      if (bus_if.imem_req_valid && !mon_prev_iv) mon_lat = 1;
      else mon_lat++;
      mon_prev_iv = bus_if.imem_req_valid;
      if (bus_if.instr_en) chk("instr_en_excl", {bus_if.rf_we, bus_if.pc_en}, 0);
      if (bus_if.rf_we) chk("rf_we_with_pc_en", bus_if.pc_en, 1);
      if (bus_if.pc_en) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("retire_rf_we", bus_if.rf_we, e.rf_we);
          chk("retire_pc_sel", bus_if.pc_sel, e.pc_sel);
          chk("retire_latency", mon_lat, e.lat);
        end
      end
    end
  end

  task automatic release_reset();
    rst_n = 1'b1;
    chk("rst_cyc1_state", bus_if.state, 0);
    chk("rst_cyc1_ivld", bus_if.imem_req_valid, 0);
    step();
    chk("rst_cyc2_state", bus_if.state, 0);
    step();
    chk("rst_fetch_state", bus_if.state, 1);
    chk("rst_fetch_ivld", bus_if.imem_req_valid, 1);
  endtask

  task automatic do_fetch(input int rdy, input int rsp, input logic early);
    int n = 0;
    while (!bus_if.imem_req_valid && n < 50) begin
      step();
      n++;
    end
    chk("fetch_req", bus_if.imem_req_valid, 1);
    repeat (rdy) begin
      step();
      chk("imem_hold", bus_if.imem_req_valid, 1);
    end
    bus_if.imem_req_ready = 1'b1;
    bus_if.imem_rsp_valid = early;
    step();
    bus_if.imem_req_ready = 1'b0;
    bus_if.imem_rsp_valid = 1'b0;
    chk("wait_i", bus_if.state, 2);
    repeat (rsp) begin
      step();
      chk("wait_i_hold", bus_if.state, 2);
    end
    bus_if.imem_rsp_valid = 1'b1;
    #1;
    chk("instr_en", bus_if.instr_en, 1);
    step();
    bus_if.imem_rsp_valid = 1'b0;
    chk("exec", bus_if.state, 3);
  endtask

  task automatic do_mem(input logic st, input int drdy, input int drsp);
    chk("mem_state", bus_if.state, 4);
    repeat (drdy) begin
      chk("dmem_vld_hold", bus_if.dmem_req_valid, 1);
      chk("dmem_we_hold", bus_if.dmem_we, st);
      chk("no_early_pc_en", bus_if.pc_en, 0);
      step();
    end
    chk("dmem_vld", bus_if.dmem_req_valid, 1);
    chk("dmem_we", bus_if.dmem_we, st);
    bus_if.dmem_req_ready = 1'b1;
    #1;
    chk("store_pc_en", bus_if.pc_en, st);
    step();
    bus_if.dmem_req_ready = 1'b0;
    if (!st) begin
      chk("wait_d", bus_if.state, 5);
      repeat (drsp) begin
        step();
        chk("wait_d_hold", bus_if.state, 5);
        chk("wait_d_no_rf_we", bus_if.rf_we, 0);
      end
      bus_if.dmem_rsp_valid = 1'b1;
      step();
      bus_if.dmem_rsp_valid = 1'b0;
      chk("wb_state", bus_if.state, 6);
      step();
    end
    chk("back_to_fetch", bus_if.state, 1);
  endtask

  task automatic set_flags(input logic ld, st, br, jmp, tk, input logic [1:0] addr, tgt, size);
    bus_if.is_load_op  = ld;
    bus_if.is_store_op = st;
    bus_if.is_br_type  = br;
    bus_if.is_jump_op  = jmp;
    bus_if.br_taken    = tk;
    bus_if.mem_addr_lo = addr;
    bus_if.tgt_addr_lo = tgt;
    bus_if.mem_size    = size;
  endtask

  task automatic run_instr(input logic ld, st, br, jmp, tk, input logic [1:0] addr, tgt, size,
                           input int rdy, rsp, input logic early, input int drdy, drsp);
    exp_t e;
    set_flags(ld, st, br, jmp, tk, addr, tgt, size);
    if (ld || st) begin
      e.rf_we  = ld;
      e.pc_sel = 1'b0;
      e.lat    = 4 + rdy + rsp + drdy + (ld ? 2 + drsp : 0);
    end else if (jmp) begin
      e.rf_we  = 1'b1;
      e.pc_sel = 1'b1;
      e.lat    = 3 + rdy + rsp;
    end else if (br) begin
      e.rf_we  = 1'b0;
      e.pc_sel = tk;
      e.lat    = 3 + rdy + rsp;
    end else begin
      e.rf_we  = 1'b1;
      e.pc_sel = 1'b0;
      e.lat    = 3 + rdy + rsp;
    end
    sb.push_back(e);
    do_fetch(rdy, rsp, early);
    step();
    if (ld || st) do_mem(st, drdy, drsp);
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic run_trap(input logic ld, st, br, jmp, tk, input logic [1:0] addr, tgt, size);
    set_flags(ld, st, br, jmp, tk, addr, tgt, size);
    do_fetch(0, 0, 1'b0);
    chk("trap_exec_pc_en", bus_if.pc_en, 0);
    chk("trap_exec_rf_we", bus_if.rf_we, 0);
    step();
    chk("trap_state", bus_if.state, 7);
    chk("trap_flag", bus_if.trap, 1);
    repeat (3) begin
      step();
      chk("trap_sticky", bus_if.trap, 1);
      chk("trap_no_dmem", bus_if.dmem_req_valid, 0);
      chk("trap_no_imem", bus_if.imem_req_valid, 0);
    end
    rst_n = 1'b0;
    #1;
    chk("trap_cleared", bus_if.trap, 0);
    step();
    set_flags(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    release_reset();
  endtask
`endif

  initial begin
    set_flags(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    bus_if.imem_req_ready = 1'b0;
    bus_if.imem_rsp_valid = 1'b0;
    bus_if.dmem_req_ready = 1'b0;
    bus_if.dmem_rsp_valid = 1'b0;
    repeat (2) step();
    chk("reset_state", bus_if.state, 0);
    chk("reset_outs", {bus_if.imem_req_valid, bus_if.instr_en, bus_if.dmem_req_valid,
                       bus_if.dmem_we, bus_if.rf_we, bus_if.pc_en, bus_if.pc_sel}, 0);
    chk("reset_trap", bus_if.trap, 0);
    release_reset();

    // Reset while a fetch is pending
    step();
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", bus_if.state, 0);
    chk("async_rst_ivld", bus_if.imem_req_valid, 0);
    step();
    release_reset();

    //        ld st br jp tk addr  tgt   size  rdy rsp early drdy drsp
    run_instr(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0,  0,  0,    0,   0);
    run_instr(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2,  1,  0,    0,   0);
    run_instr(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0,  1,  1,    0,   0);
    run_instr(0, 0, 1, 0, 0, 2'd0, 2'd2, 2'd0, 0,  0,  0,    0,   0);
    run_instr(0, 0, 1, 0, 1, 2'd0, 2'd0, 2'd0, 0,  0,  0,    0,   0);
    run_instr(0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 0,  0,  0,    0,   0);
    run_instr(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd2, 0,  0,  0,    0,   0);
    run_instr(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 0,  0,  0,    3,   1);
    run_instr(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 0,  0,  0,    0,   0);
    run_instr(1, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 1,  0,  0,    0,   0);
    run_instr(0, 1, 0, 0, 0, 2'd2, 2'd0, 2'd1, 0,  0,  0,    2,   0);
`ifdef MISALIGN_TRAP_EN
    run_trap(0, 1, 0, 0, 0, 2'd2, 2'd0, 2'd2);
    run_trap(1, 0, 0, 0, 0, 2'd1, 2'd0, 2'd1);
    run_trap(0, 0, 1, 1, 0, 2'd0, 2'd2, 2'd0);
`else
    run_instr(0, 1, 0, 0, 0, 2'd2, 2'd0, 2'd2, 0,  0,  0,    0,   0);
    run_instr(0, 0, 1, 1, 0, 2'd0, 2'd2, 2'd0, 0,  0,  0,    0,   0);
    run_instr(0, 0, 1, 0, 1, 2'd0, 2'd2, 2'd0, 0,  0,  0,    0,   0);
`endif

    // Reset while waiting for load data; a late response must not restart the FSM
    set_flags(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2);
    do_fetch(0, 0, 1'b0);
    step();
    bus_if.dmem_req_ready = 1'b1;
    step();
    bus_if.dmem_req_ready = 1'b0;
    chk("abort_wait_d", bus_if.state, 5);
    rst_n = 1'b0;
    #1;
    chk("abort_rst_state", bus_if.state, 0);
    step();
    set_flags(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0);
    bus_if.dmem_rsp_valid = 1'b1;
    release_reset();
    bus_if.dmem_rsp_valid = 1'b0;

    run_instr(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0);
    repeat (3) step();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
